ifm_row_loader: RTL and testbench

Producer side of the IFM row-buffer handshake. Accepts a stream of input-feature-map tile words and writes them row by row into a ring of `IFM_BUF_CNT` row buffers (row r → buffer r mod `IFM_BUF_CNT`). It raises the per-buffer `o_ifm_buf_done` flags that the CNN scan controller consumes. It stalls when every buffer is held, and frees a buffer when the consumer pulses `i_row_release`.

---
 rtl/ifm_row_loader_if.sv | 11 +
 rtl/ifm_row_loader.sv | 214 +++++++++++++++++++++
 tb/tb_ifm_row_loader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_row_loader_if.sv
// rtl/ifm_row_loader_if.sv - tile-word stream handshake bundle for ifm_row_loader
interface ifm_row_loader_if #(
  parameter int W_DATA = 32
);
  logic [W_DATA-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ifm_row_loader.sv
// rtl/ifm_row_loader.sv - writes IFM tile rows into a ring of row buffers; IFM_ROW_LOADER_STALL_CNT_EN adds o_stall_cnt
module ifm_row_loader #(
  parameter int W_SIZE      = 8,
  parameter int W_CHANNEL   = 6,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_DATA      = 32,
  parameter int W_ADDR      = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_start,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic [W_SIZE-1:0]      q_height,
  input  logic [W_CHANNEL-1:0]   q_channel,
  ifm_row_loader_if.slave        s_axis,
  input  logic                   i_row_release,
  output logic [IFM_BUF_CNT-1:0] o_buf_we,
  output logic [W_ADDR-1:0]      o_buf_addr,
  output logic [W_DATA-1:0]      o_buf_wdata,
  output logic [IFM_BUF_CNT-1:0] o_ifm_buf_done,
  output logic                   o_load_done
`ifdef IFM_ROW_LOADER_STALL_CNT_EN
  ,
  output logic [31:0]            o_stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam int W_LIM = W_ADDR + 1;
  localparam logic [W_IFM_BUF:0]     OCC_FULL = (W_IFM_BUF + 1)'(IFM_BUF_CNT);
  localparam logic [IFM_BUF_CNT-1:0] BUF_ONE  = {{(IFM_BUF_CNT - 1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [W_LIM-1:0]       row_lim_q, row_lim_d;
  logic [W_SIZE-1:0]      height_m1_q, height_m1_d;
  logic [W_ADDR-1:0]      word_q, word_d;
  logic [W_SIZE-1:0]      row_q, row_d;
  logic [W_IFM_BUF-1:0]   wptr_q, wptr_d;
  logic [W_IFM_BUF-1:0]   rptr_q, rptr_d;
  logic [W_IFM_BUF:0]     occ_q, occ_d;
  logic [IFM_BUF_CNT-1:0] done_q, done_d;
  logic                   ready_q, ready_d;
  logic [IFM_BUF_CNT-1:0] we_q, we_d;
  logic [W_ADDR-1:0]      addr_q, addr_d;
  logic [W_DATA-1:0]      wdata_q, wdata_d;
  logic                   last_q, last_d;
  logic                   load_done_q, load_done_d;

  logic [W_LIM-1:0] row_lim_in;
  logic             hs, alloc, rel, last_word, last_row;

  // Address equals the in-row word index because the stream is channel-fastest.
  assign row_lim_in = W_LIM'(q_width) * W_LIM'(q_channel) - W_LIM'(1);
  assign hs         = (state_q == S_FILL) && s_axis.s_valid;
  assign alloc      = hs && (word_q == '0);
  assign rel        = i_row_release && (occ_q != '0);
  assign last_word  = ({1'b0, word_q} == row_lim_q);
  assign last_row   = (row_q == height_m1_q);

  always_comb begin
    state_d     = state_q;
    row_lim_d   = row_lim_q;
    height_m1_d = height_m1_q;
    word_d      = word_q;
    row_d       = row_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    done_d      = done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = '0;
    last_d      = 1'b0;
    load_done_d = 1'b0;

    case ({alloc, rel})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (rel) begin
      done_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + 1'b1;
    end
    // Commit of a row's final word sets its done bit after any same-cycle clear.
    if (last_q) begin
      done_d = done_d | we_q;
    end

    case (state_q)
      S_IDLE: begin
        if (q_start) begin
          state_d     = S_FILL;
          row_lim_d   = row_lim_in;
          height_m1_d = q_height - 1'b1;
          word_d      = '0;
          row_d       = '0;
          wptr_d      = '0;
          rptr_d      = '0;
          occ_d       = '0;
          done_d      = '0;
        end
      end
      S_FILL: begin
        if (hs) begin
          we_d    = BUF_ONE << wptr_q;
          addr_d  = word_q;
          wdata_d = s_axis.s_data;
          if (last_word) begin
            last_d = 1'b1;
            word_d = '0;
            row_d  = row_q + 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (last_row) begin
              state_d = S_FLUSH;
            end else if (occ_d == OCC_FULL) begin
              state_d = S_WAIT;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (occ_q < OCC_FULL) begin
          state_d = S_FILL;
        end
      end
      default: begin
        // First FLUSH cycle carries the final write; done is visible on the next.
        if (we_q == '0) begin
          load_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase

    ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_lim_q   <= '0;
      height_m1_q <= '0;
      word_q      <= '0;
      row_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      done_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_lim_q   <= row_lim_d;
      height_m1_q <= height_m1_d;
      word_q      <= word_d;
      row_q       <= row_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      load_done_q <= load_done_d;
    end
  end

  assign s_axis.s_ready = ready_q;
  assign o_buf_we       = we_q;
  assign o_buf_addr     = addr_q;
  assign o_buf_wdata    = wdata_q;
  assign o_ifm_buf_done = done_q;
  assign o_load_done    = load_done_q;

`ifdef IFM_ROW_LOADER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && q_start) begin
      stall_cnt_d = '0;
    end else if (((state_q == S_WAIT) || ((state_q == S_FILL) && !s_axis.s_valid)) &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifm_row_loader.sv
// tb/tb_ifm_row_loader.sv - randomized self-checking bench for ifm_row_loader
module tb_ifm_row_loader;
  localparam int CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_start = 1'b0;
  logic [7:0]  q_width = 8'd1;
  logic [7:0]  q_height = 8'd1;
  logic [5:0]  q_channel = 6'd1;
  logic        i_row_release = 1'b0;
  logic [3:0]  o_buf_we;
  logic [11:0] o_buf_addr;
  logic [31:0] o_buf_wdata;
  logic [3:0]  o_ifm_buf_done;
  logic        o_load_done;
`ifdef IFM_ROW_LOADER_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  ifm_row_loader_if #(.W_DATA(32)) s_if ();

  always #5 clk = ~clk;

  ifm_row_loader dut (
    .clk            (clk),
    .rst            (rst),
    .q_start        (q_start),
    .q_width        (q_width),
    .q_height       (q_height),
    .q_channel      (q_channel),
    .s_axis         (s_if),
    .i_row_release  (i_row_release),
    .o_buf_we       (o_buf_we),
    .o_buf_addr     (o_buf_addr),
    .o_buf_wdata    (o_buf_wdata),
    .o_ifm_buf_done (o_ifm_buf_done),
`ifdef IFM_ROW_LOADER_STALL_CNT_EN
    .o_stall_cnt    (o_stall_cnt),
`endif
    .o_load_done    (o_load_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame word index k maps to row k/rowlen, address k%rowlen,
  // buffer row%CNT; held buffers are a FIFO in allocation order.
  int          k = 0, n_words = 0, rowlen = 1, h_l = 1;
  int          alloc_q[$];
  logic [3:0]  exp_done = 4'b0;
  bit          pend_v = 0, pend_final = 0, ld_arm = 0, exp_ld = 0;
  int          pend_buf = 0;
  bit          ew_v = 0;
  int          ew_buf = 0, ew_addr = 0;
  logic [31:0] ew_data = 32'b0;
  int          stall_inj = 0;

  task automatic model_clear();
    k = 0; n_words = 0; alloc_q.delete(); exp_done = 4'b0;
    pend_v = 0; pend_final = 0; ld_arm = 0; exp_ld = 0; ew_v = 0;
  endtask

  task automatic step(input bit v, input bit rel, input bit st);
    logic [31:0] d;
    logic [3:0]  ewe;
    bit          hs;
    int          b, row, addr;
    d = $urandom;
    s_if.s_valid  = v;
    s_if.s_data   = d;
    i_row_release = rel;
    q_start       = st;
    hs = v && s_if.s_ready;
    if (alloc_q.size() == CNT && k < n_words && (k % rowlen) == 0) begin
      checks++;
      if (s_if.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL ring_full_ready: got %b expected 0 at word %0d", s_if.s_ready, k);
      end
    end
    @(posedge clk);
    exp_ld = ld_arm;
    ld_arm = 0;
    if (rel && alloc_q.size() > 0) begin
      b = alloc_q.pop_front();
      exp_done[b] = 1'b0;
    end
    if (pend_v) begin
      exp_done[pend_buf] = 1'b1;
      ld_arm = pend_final;
      pend_v = 0;
    end
    ew_v = 0;
    if (hs) begin
      row  = k / rowlen;
      addr = k % rowlen;
      b    = row % CNT;
      if (addr == 0) alloc_q.push_back(b);
      ew_v = 1; ew_buf = b; ew_addr = addr; ew_data = d;
      if (addr == rowlen - 1) begin
        pend_v = 1; pend_buf = b; pend_final = (row == h_l - 1);
      end
      k++;
    end
    @(negedge clk);
    q_start = 1'b0;
    i_row_release = 1'b0;
    ewe = 4'b0;
    if (ew_v) ewe[ew_buf] = 1'b1;
    checks++;
    if (o_buf_we !== ewe) begin
      errors++;
      $display("FAIL buf_we: got %b expected %b", o_buf_we, ewe);
    end
    if (ew_v) begin
      checks += 2;
      if (o_buf_addr !== 12'(ew_addr)) begin
        errors++;
        $display("FAIL buf_addr: got %0d expected %0d", o_buf_addr, ew_addr);
      end
      if (o_buf_wdata !== ew_data) begin
        errors++;
        $display("FAIL buf_wdata: got %h expected %h", o_buf_wdata, ew_data);
      end
    end
    checks += 2;
    if (o_ifm_buf_done !== exp_done) begin
      errors++;
      $display("FAIL buf_done: got %b expected %b", o_ifm_buf_done, exp_done);
    end
    if (o_load_done !== exp_ld) begin
      errors++;
      $display("FAIL load_done: got %b expected %b", o_load_done, exp_ld);
    end
  endtask

  task automatic start_frame(input int w, input int h, input int c);
    q_width = 8'(w); q_height = 8'(h); q_channel = 6'(c);
    q_start = 1'b1; s_if.s_valid = 1'b0; i_row_release = 1'b0;
    @(posedge clk);
    model_clear();
    rowlen = w * c; h_l = h; n_words = rowlen * h;
    @(negedge clk);
    q_start = 1'b0;
    q_width = 8'($urandom); q_height = 8'($urandom); q_channel = 6'($urandom);
    checks += 2;
    if (s_if.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: got %b expected 1", s_if.s_ready);
    end
    if (o_ifm_buf_done !== 4'b0) begin
      errors++;
      $display("FAIL start_done: got %b expected 0000", o_ifm_buf_done);
    end
  endtask

  task automatic finish_frame(input int vpct, input int relpct);
    int budget = 0;
    bit v, rel;
    while (!exp_ld && budget < 3000) begin
      v   = (k < n_words) && ($urandom_range(99) < vpct);
      rel = (alloc_q.size() > 0) && exp_done[alloc_q[0]] && ($urandom_range(99) < relpct);
      step(v, rel, 1'b0);
      budget++;
    end
    checks++;
    if (!exp_ld) begin
      errors++;
      $display("FAIL frame_timeout: got %0d words of %0d expected load_done", k, n_words);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", s_if.s_ready); end
    if (o_buf_we !== 4'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", o_buf_we); end
    if (o_buf_addr !== 12'b0) begin errors++; $display("FAIL rst_addr: got %h expected 0", o_buf_addr); end
    if (o_buf_wdata !== 32'b0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", o_buf_wdata); end
    if (o_ifm_buf_done !== 4'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", o_ifm_buf_done); end
    if (o_load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %b expected 0", o_load_done); end
  endtask

  task automatic test_basic_frame();
    start_frame(4, 2, 2);
    finish_frame(100, 100);
  endtask

  task automatic test_ring_stall();
    start_frame(2, 6, 1);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    checks += 2;
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", s_if.s_ready); end
    if (o_ifm_buf_done !== 4'b1111) begin errors++; $display("FAIL stall_done: got %b expected 1111", o_ifm_buf_done); end
    step(1'b1, 1'b1, 1'b0);
    checks += 2;
    if (o_ifm_buf_done !== 4'b1110) begin errors++; $display("FAIL release_done: got %b expected 1110", o_ifm_buf_done); end
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL release_ready_t1: got %b expected 0", s_if.s_ready); end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL release_ready_t2: got %b expected 1", s_if.s_ready); end
    // Release lands on the same edge as row 4's first-word allocation.
    step(1'b1, 1'b1, 1'b0);
    finish_frame(100, 0);
  endtask

  task automatic test_gapped_stream();
    start_frame(3, 3, 3);
    finish_frame(60, 70);
  endtask

  task automatic test_reset_mid_row();
    int budget = 0;
    start_frame(4, 3, 2);
    while (k < 13 && budget < 200) begin
      step(1'b1, (alloc_q.size() > 0) && exp_done[alloc_q[0]], 1'b0);
      budget++;
    end
    s_if.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    test_reset();
`ifdef IFM_ROW_LOADER_STALL_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", o_stall_cnt); end
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_frame(4, 2, 2);
    finish_frame(100, 100);
  endtask

  task automatic test_ignored_start_release();
    start_frame(2, 2, 1);
    stall_inj = 0;
    step(1'b0, 1'b1, 1'b0);
    stall_inj++;
    step(1'b1, 1'b0, 1'b0);
    q_width = 8'd7; q_height = 8'd9; q_channel = 6'd3;
    step(1'b1, 1'b0, 1'b1);
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0);
      stall_inj++;
    end
    checks++;
    if (o_ifm_buf_done !== 4'b0001) begin errors++; $display("FAIL ignored_done: got %b expected 0001", o_ifm_buf_done); end
    finish_frame(100, 100);
`ifdef IFM_ROW_LOADER_STALL_CNT_EN
    checks++;
    if (o_stall_cnt !== 32'(stall_inj)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected %0d", o_stall_cnt, stall_inj);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      start_frame($urandom_range(5, 1), $urandom_range(7, 1), $urandom_range(3, 1));
      finish_frame($urandom_range(100, 50), $urandom_range(100, 30));
    end
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = 32'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic_frame();
    test_ring_stall();
    test_gapped_stream();
    test_reset_mid_row();
    test_ignored_start_release();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
